demux1to3_buf: RTL
==================

# demux1to3_buf

Registered 1-to-3 steering unit: the opposite direction of the datapath 3-to-1 select mux. One valid/ready input stream is routed, word by word, to one of three valid/ready output channels. The route is chosen by a 2-bit select that uses the mux's encoding. Each output channel has a one-entry holding register. Code 2'b11 is the "null" route: the word is accepted and discarded, mirroring the mux's zero output. The block sits between the CPU core and up to three consumers, e.g. register writeback, data-memory store port and debug/LED port.

## Interface
- WIDTH, 32: data width of input and all outputs.
- CNT_W, 8: width of the saturating drop counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- sel  in  2  route for the current input word: 00→ch1, 01→ch2, 10→ch3, 11→drop. Sampled only with in_valid.
- in_data  in  WIDTH  input word.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- outN_data  out  WIDTH  (N=1,2,3) channel N holding-register contents.
- outN_valid  out  1  channel N holds a word.
- outN_ready  in  1  channel N consumer takes the word this cycle.
- drop_count  out  CNT_W  number of words accepted with sel=11. Saturates at all-ones.
- busy  out  1  OR of out1_valid, out2_valid, out3_valid.

## Operation
- Input transfer: in_valid & in_ready at a rising edge.
- Output transfer: outN_valid & outN_ready at a rising edge.
- Each channel holding register has two states.
  - EMPTY→FULL: input transfer with sel routed to this channel.
  - FULL→EMPTY: output transfer with no new routed input transfer.
  - FULL→FULL with new data: output transfer and routed input transfer in the same cycle (pass-through, no bubble).
- in_ready is combinational from sel, the channel state and outN_ready:
  - sel=00/01/10: in_ready = !outN_valid | outN_ready for the selected N.
  - sel=11: in_ready = 1.
- in_ready must not depend on in_valid.
- An input transfer loads in_data into only the selected channel. The other channels' data and valid bits are unchanged.
- outN_data is held stable while outN_valid=1 and the word is not taken.
- outN_data is undefined-but-stable while outN_valid=0; RTL holds the last value.
- Drop: on an input transfer with sel=11, no channel changes and drop_count increments by 1. At 2^CNT_W−1 it saturates and never wraps.
- Per-channel ordering is preserved. There is no ordering guarantee between channels.
- sel changing while in_valid=1 and in_ready=0 is legal. The route is re-evaluated every cycle, with no latching of sel.

## Timing
- Reset, asynchronous with rst_n=0:
  - out1/2/3_valid=0, out1/2/3_data=0, drop_count=0, busy=0.
  - in_ready follows its combinational rule with all channels EMPTY, so it is 1.
- Reset asserted mid-transfer: held words are discarded. No output transfer occurs on an edge while rst_n=0.
- Release is synchronous-safe: the first transfer can occur on the first rising edge with rst_n=1.
- Latency: in_data appears on outN_data with outN_valid=1 one cycle after the input transfer edge.
- Throughput per channel: 1 word/cycle while outN_ready is held high.
- Throughput for sel=11: 1 word/cycle, unconditionally.
- Back-pressure on channel N stalls only input words routed to N.

## Test plan
- Reset: hold rst_n=0 with in_valid=1, sel=00 and in_data=0xDEADBEEF for 3 cycles.
  → All outN_valid=0, data=0, drop_count=0, in_ready=1.
  → Nothing is loaded until rst_n=1.
- Basic route: with all outN_ready=1, send 0x11111111/sel=00, then 0x22222222/sel=01, then 0x33333333/sel=10 on consecutive cycles.
  → Each word appears on out1, out2 and out3 respectively, 1 cycle after its transfer, each valid for exactly 1 cycle.
- Back-pressure: out2_ready=0, send 0xA to ch2, then 0xB to ch2.
  → out2_data=0xA held and in_ready=0 for the second word.
  → Raise out2_ready: 0xA is taken and 0xB is accepted on the same edge. 0xB is valid the next cycle with no bubble.
- Independence: ch1 full with out1_ready=0, send 0x5 to ch3.
  → in_ready=1 and out3 gets 0x5.
  → out1_data and out1_valid are unchanged.
- Drop and saturation: with CNT_W=8, send 300 words with sel=11.
  → in_ready=1 throughout and no outN_valid rises.
  → drop_count reads 255 and stays 255.
- Mid-operation reset: all channels FULL, drop_count=7, pulse rst_n low between clock edges.
  → All valids and drop_count go to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/demux1to3_buf_if.sv
// Valid/ready bundle for the 1-to-3 steering unit: one input stream, three output channels,
// plus drop statistics. The master side feeds input words and consumes the output channels.
interface demux1to3_buf_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic [1:0]       sel;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out2_data;
  logic             out2_valid;
  logic             out2_ready;
  logic [WIDTH-1:0] out3_data;
  logic             out3_valid;
  logic             out3_ready;

  logic [CNT_W-1:0] drop_count;
  logic             busy;

  modport master (
    output sel, in_data, in_valid, out1_ready, out2_ready, out3_ready,
    input  in_ready, out1_data, out1_valid, out2_data, out2_valid,
           out3_data, out3_valid, drop_count, busy
  );

  modport slave (
    input  sel, in_data, in_valid, out1_ready, out2_ready, out3_ready,
    output in_ready, out1_data, out1_valid, out2_data, out2_valid,
           out3_data, out3_valid, drop_count, busy
  );
endinterface

// File: rtl/demux1to3_buf.sv
// Registered 1-to-3 steering unit: each input word goes to one of three single-entry
// holding registers, or is counted and discarded when sel=11.
//
// state | meaning (per channel, encoded by valid_q[n])
// EMPTY | no word held, channel can accept unconditionally
// FULL  | word held on outN_data until the consumer takes it
module demux1to3_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  demux1to3_buf_if.slave bus
);
  logic [WIDTH-1:0] data_q [3];
  logic [2:0]       valid_q;
  logic [2:0]       out_ready;
  logic [2:0]       take;
  logic [CNT_W-1:0] drop_q;
  logic             in_ready_c;
  logic             xfer_in;

  assign out_ready = {bus.out3_ready, bus.out2_ready, bus.out1_ready};
  assign take      = valid_q & out_ready;

  // A full channel can still accept when its consumer takes the held word on the same edge.
  always_comb begin
    in_ready_c = 1'b1;
    case (bus.sel)
      2'b00:   in_ready_c = !valid_q[0] | out_ready[0];
      2'b01:   in_ready_c = !valid_q[1] | out_ready[1];
      2'b10:   in_ready_c = !valid_q[2] | out_ready[2];
      default: in_ready_c = 1'b1;
    endcase
  end

  assign xfer_in = bus.in_valid & in_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      drop_q  <= '0;
      for (int i = 0; i < 3; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (xfer_in && bus.sel == 2'(i)) begin
          data_q[i]  <= bus.in_data;
          valid_q[i] <= 1'b1;
        end else if (take[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (xfer_in && bus.sel == 2'b11 && drop_q != '1)
        drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out1_data  = data_q[0];
  assign bus.out2_data  = data_q[1];
  assign bus.out3_data  = data_q[2];
  assign bus.out1_valid = valid_q[0];
  assign bus.out2_valid = valid_q[1];
  assign bus.out3_valid = valid_q[2];
  assign bus.drop_count = drop_q;
  assign bus.busy       = |valid_q;
endmodule
